// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA capture front end.
package vga_pkg;

  // Standard 640x480 @ 60 Hz timing, kept here as the reference frame geometry.
  localparam int H_ACTIVE_STD = 640;
  localparam int V_ACTIVE_STD = 480;
  localparam int H_TOTAL      = 800;
  localparam int V_TOTAL      = 525;
  localparam int H_SYNC_W     = 96;
  localparam int V_SYNC_W     = 2;

  // Both syncs from the driver are active low.
  localparam logic SYNC_ACTIVE = 1'b0;

  // CLOCK_50 cycles without a pixel strobe before the stream is declared lost.
  localparam int LOS_CYCLES = 64;

  typedef enum logic {
    SEARCH,
    SYNCED
  } cap_state_t;

endpackage

// File: rtl/vga_edge_sampler.sv
// Registers the VGA pins once on CLOCK_50, finds the VGA_CLK falling edge
// and derives sync/blank edge events from the values sampled at that edge.
module vga_edge_sampler
  import vga_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       i_vga_clk,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic       i_blank_n,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  output logic       o_strobe,
  output logic       o_vs_fall,
  output logic       o_bl_rise,
  output logic       o_bl_fall,
  output logic       o_blank_n,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b
);

  logic       r_s1_clk;
  logic       r_prev_clk;
  logic       r_s1_hs;
  logic       r_s1_vs;
  logic       r_s1_bl;
  logic [7:0] r_s1_r;
  logic [7:0] r_s1_g;
  logic [7:0] r_s1_b;
  logic       r_last_vs;
  logic       r_last_bl;
  logic       w_hs_unused;

  // Input stage plus the sync/blank values seen at the previous strobe.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_clk   <= 1'b0;
      r_prev_clk <= 1'b0;
      r_s1_hs    <= 1'b0;
      r_s1_vs    <= 1'b0;
      r_s1_bl    <= 1'b0;
      r_s1_r     <= '0;
      r_s1_g     <= '0;
      r_s1_b     <= '0;
      // Start "in sync" so a VS already low at reset release is not a fall.
      r_last_vs  <= SYNC_ACTIVE;
      r_last_bl  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value of the others.
      r_s1_clk   <= i_vga_clk;
      r_prev_clk <= r_s1_clk;
      r_s1_hs    <= i_hs;
      r_s1_vs    <= i_vs;
      r_s1_bl    <= i_blank_n;
      r_s1_r     <= i_r;
      r_s1_g     <= i_g;
      r_s1_b     <= i_b;
      if (o_strobe) begin
        r_last_vs <= r_s1_vs;
        r_last_bl <= r_s1_bl;
      end
    end
  end

  // Falling VGA_CLK lands mid-period, when the driver's data is stable.
  assign o_strobe  = r_prev_clk & ~r_s1_clk;
  assign o_vs_fall = o_strobe & (r_last_vs != SYNC_ACTIVE) & (r_s1_vs == SYNC_ACTIVE);
  assign o_bl_rise = o_strobe & ~r_last_bl &  r_s1_bl;
  assign o_bl_fall = o_strobe &  r_last_bl & ~r_s1_bl;
  assign o_blank_n = r_s1_bl;
  assign o_r       = r_s1_r;
  assign o_g       = r_s1_g;
  assign o_b       = r_s1_b;

  // HS is sampled alongside the other pins; line framing comes from BLANK_N.
  assign w_hs_unused = r_s1_hs;

endmodule

// File: rtl/vga_capture.sv
// Recovers a pixel stream with x/y coordinates from the VGA bus and
// verifies line/frame geometry before declaring the stream locked.
module vga_capture
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       VGA_CLK,
  input  logic       VGA_HS,
  input  logic       VGA_VS,
  input  logic       VGA_BLANK_N,
  input  logic [7:0] VGA_R,
  input  logic [7:0] VGA_G,
  input  logic [7:0] VGA_B,
  input  logic       clear_err,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       line_end,
  output logic       locked,
  output logic       h_err,
  output logic       v_err
);

  localparam logic [9:0] H_CMP    = 10'(H_ACTIVE);
  localparam logic [8:0] V_CMP    = 9'(V_ACTIVE);
  localparam logic [3:0] LOCK_CMP = 4'(LOCK_FRAMES);
  localparam logic [5:0] LOS_LAST = 6'(LOS_CYCLES - 1);

  logic       w_strobe, w_vs_fall, w_bl_rise, w_bl_fall, w_blank_n;
  logic [7:0] w_r, w_g, w_b;

  cap_state_t r_state, w_state_nx;
  logic [9:0] r_x_cnt, w_x_nx;
  logic [8:0] r_line_cnt, w_line_nx;
  logic       r_frame_good, w_fg_nx;
  logic [3:0] r_good_cnt, w_good_nx;
  logic       r_pix_en, w_pix_en_nx;
  logic [5:0] r_idle_cnt, w_idle_nx;
  logic       w_locked_nx, w_h_set, w_v_set, w_pv, w_fs, w_le;
  logic [9:0] w_x_out;
  logic [8:0] w_y_out;
  logic [7:0] w_r_out, w_g_out, w_b_out;

  vga_edge_sampler u_sampler (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .i_vga_clk (VGA_CLK),
    .i_hs      (VGA_HS),
    .i_vs      (VGA_VS),
    .i_blank_n (VGA_BLANK_N),
    .i_r       (VGA_R),
    .i_g       (VGA_G),
    .i_b       (VGA_B),
    .o_strobe  (w_strobe),
    .o_vs_fall (w_vs_fall),
    .o_bl_rise (w_bl_rise),
    .o_bl_fall (w_bl_fall),
    .o_blank_n (w_blank_n),
    .o_r       (w_r),
    .o_g       (w_g),
    .o_b       (w_b)
  );

  // Next-state, counters and output decisions; only strobes or signal loss move state.
  always_comb begin
    // NOTE: everything gets a default before any branch so no path infers a latch.
    w_state_nx  = r_state;
    w_x_nx      = r_x_cnt;
    w_line_nx   = r_line_cnt;
    w_fg_nx     = r_frame_good;
    w_good_nx   = r_good_cnt;
    w_pix_en_nx = r_pix_en;
    w_idle_nx   = r_idle_cnt + 6'd1;
    w_locked_nx = locked;
    w_h_set     = 1'b0;
    w_v_set     = 1'b0;
    w_pv        = 1'b0;
    w_fs        = 1'b0;
    w_le        = 1'b0;
    w_x_out     = x;
    w_y_out     = y;
    w_r_out     = r;
    w_g_out     = g;
    w_b_out     = b;

    if (w_strobe) begin
      w_idle_nx = '0;
      if (r_state == SEARCH) begin
        if (w_vs_fall) begin
          w_state_nx  = SYNCED;
          w_x_nx      = '0;
          w_line_nx   = '0;
          w_fg_nx     = 1'b1;
          // A line already in progress at entry is skipped until BLANK_N rises.
          w_pix_en_nx = 1'b0;
        end
      end else begin
        // A VS fall with BLANK_N still high closes the line as a truncated one.
        if (r_pix_en && (w_bl_fall || (w_vs_fall && w_blank_n))) begin
          w_le = 1'b1;
          if (r_x_cnt != H_CMP) begin
            w_h_set     = 1'b1;
            w_fg_nx     = 1'b0;
            w_locked_nx = 1'b0;
          end
          w_x_nx = '0;
          if (r_line_cnt != '1) w_line_nx = r_line_cnt + 9'd1;
        end
        if (w_vs_fall) begin
          if (w_line_nx != V_CMP) begin
            w_v_set = 1'b1;
            w_fg_nx = 1'b0;
          end
          if (w_fg_nx) begin
            if (r_good_cnt < LOCK_CMP) w_good_nx = r_good_cnt + 4'd1;
            if (w_good_nx == LOCK_CMP) w_locked_nx = 1'b1;
          end else begin
            w_good_nx   = '0;
            w_locked_nx = 1'b0;
          end
          w_line_nx = '0;
          w_x_nx    = '0;
          w_fg_nx   = 1'b1;
        end else if (w_blank_n && (r_pix_en || w_bl_rise)) begin
          w_pix_en_nx = 1'b1;
          w_pv        = 1'b1;
          w_fs        = (r_x_cnt == '0) && (r_line_cnt == '0);
          w_x_out     = r_x_cnt;
          w_y_out     = r_line_cnt;
          w_r_out     = w_r;
          w_g_out     = w_g;
          w_b_out     = w_b;
          if (r_x_cnt != '1) w_x_nx = r_x_cnt + 10'd1;
        end
      end
    end else if (r_idle_cnt == LOS_LAST) begin
      // VGA_CLK has stopped: drop back and require fresh good frames.
      w_state_nx  = SEARCH;
      w_locked_nx = 1'b0;
      w_good_nx   = '0;
      w_fg_nx     = 1'b0;
    end
  end

  // State, counters and registered outputs; pulses fall back to 0 on non-strobe cycles.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= SEARCH;
      r_x_cnt      <= '0;
      r_line_cnt   <= '0;
      r_frame_good <= 1'b0;
      r_good_cnt   <= '0;
      r_pix_en     <= 1'b0;
      r_idle_cnt   <= '0;
      x            <= '0;
      y            <= '0;
      r            <= '0;
      g            <= '0;
      b            <= '0;
      pixel_valid  <= 1'b0;
      frame_start  <= 1'b0;
      line_end     <= 1'b0;
      locked       <= 1'b0;
      h_err        <= 1'b0;
      v_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_x_cnt      <= w_x_nx;
      r_line_cnt   <= w_line_nx;
      r_frame_good <= w_fg_nx;
      r_good_cnt   <= w_good_nx;
      r_pix_en     <= w_pix_en_nx;
      r_idle_cnt   <= w_idle_nx;
      x            <= w_x_out;
      y            <= w_y_out;
      r            <= w_r_out;
      g            <= w_g_out;
      b            <= w_b_out;
      pixel_valid  <= w_pv;
      frame_start  <= w_fs;
      line_end     <= w_le;
      locked       <= w_locked_nx;
      // A new error beats a simultaneous clear.
      h_err        <= w_h_set | (h_err & ~clear_err);
      v_err        <= w_v_set | (v_err & ~clear_err);
    end
  end

endmodule
